// File: rtl/clock_pkg.sv
// Shared encodings and limits for the board clock core and its field counters.
package clock_pkg;

  localparam int unsigned SEC_W = 6;
  localparam int unsigned HR_W  = 5;
  localparam int unsigned CUR_W = 3;

  localparam int unsigned SEC_MAX = 59;
  localparam int unsigned MIN_MAX = 59;
  localparam int unsigned HR_MAX  = 23;

  localparam logic [CUR_W-1:0] FLD_SEC     = 3'd0;
  localparam logic [CUR_W-1:0] FLD_MIN     = 3'd1;
  localparam logic [CUR_W-1:0] FLD_HR      = 3'd2;
  localparam logic [CUR_W-1:0] FLD_ALM_MIN = 3'd3;
  localparam logic [CUR_W-1:0] FLD_ALM_HR  = 3'd4;

  typedef enum logic {
    ST_RUN = 1'b0,
    ST_SET = 1'b1
  } state_t;

endpackage

// File: rtl/clock_core_gen2_if.sv
// Button/tick inputs and display outputs of the clock core; alarm signals exist only with CLOCK_ALARM_EN.
interface clock_core_gen2_if;
  import clock_pkg::*;

  logic             i_ms_pulse;
  logic             i_set;
  logic             i_up;
  logic             i_down;
  logic             i_left;
  logic             i_right;
  logic             i_summertime;
  logic             i_mode_12h;
  logic [SEC_W-1:0] o_sec;
  logic [SEC_W-1:0] o_min;
  logic [HR_W-1:0]  o_hr;
  logic             o_pm;
  logic             o_set_active;
  logic [CUR_W-1:0] o_cursor;
  logic             o_sec_pulse;
`ifdef CLOCK_ALARM_EN
  logic [SEC_W-1:0] o_alm_min;
  logic [HR_W-1:0]  o_alm_hr;
  logic             o_alarm;

  modport master (
    output i_ms_pulse, i_set, i_up, i_down, i_left, i_right, i_summertime, i_mode_12h,
    input  o_sec, o_min, o_hr, o_pm, o_set_active, o_cursor, o_sec_pulse,
           o_alm_min, o_alm_hr, o_alarm
  );
  modport slave (
    input  i_ms_pulse, i_set, i_up, i_down, i_left, i_right, i_summertime, i_mode_12h,
    output o_sec, o_min, o_hr, o_pm, o_set_active, o_cursor, o_sec_pulse,
           o_alm_min, o_alm_hr, o_alarm
  );
`else
  modport master (
    output i_ms_pulse, i_set, i_up, i_down, i_left, i_right, i_summertime, i_mode_12h,
    input  o_sec, o_min, o_hr, o_pm, o_set_active, o_cursor, o_sec_pulse
  );
  modport slave (
    input  i_ms_pulse, i_set, i_up, i_down, i_left, i_right, i_summertime, i_mode_12h,
    output o_sec, o_min, o_hr, o_pm, o_set_active, o_cursor, o_sec_pulse
  );
`endif

endinterface

// File: rtl/clock_field_ctr.sv
// Modulo-(MAX+1) up/down counter for one time field; carry_c flags an increment wrapping MAX->0.
module clock_field_ctr #(
  parameter int unsigned MAX     = 59,
  parameter int unsigned W       = 6,
  parameter int unsigned RST_VAL = 0
) (
  input  logic         i_clk,
  input  logic         i_rstn,
  input  logic         inc,
  input  logic         dec,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] val,
  output logic         carry_c
);

  logic at_max;
  assign at_max  = (val == W'(MAX));
  assign carry_c = inc && !dec && !load && at_max;

  // Opposing inc/dec in the same cycle cancel out.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      val <= W'(RST_VAL);
    end else if (load) begin
      val <= load_val;
    end else if (inc && !dec) begin
      val <= at_max ? '0 : val + W'(1);
    end else if (dec && !inc) begin
      val <= (val == '0) ? W'(MAX) : val - W'(1);
    end
  end

endmodule

// File: rtl/clock_core_gen2.sv
// Board clock core: ms-tick prescaler, sec/min/hr chain, SET-mode field editing, 12/24 h display.
// Optional alarm registers and alarm flag are built when CLOCK_ALARM_EN is defined.
module clock_core_gen2
  import clock_pkg::*;
#(
  parameter  int unsigned TICKS_PER_SEC = 1000,
  localparam int unsigned TICK_W        = $clog2(TICKS_PER_SEC)
) (
  input logic              i_clk,
  input logic              i_rstn,
  clock_core_gen2_if.slave bus
);

`ifdef CLOCK_ALARM_EN
  localparam logic [CUR_W-1:0] FLD_LAST = FLD_ALM_HR;
`else
  localparam logic [CUR_W-1:0] FLD_LAST = FLD_HR;
`endif

  localparam int unsigned NEV = 5;

  logic [NEV-1:0] raw, in_q, in_d, ev;
  logic           set_q;
  logic           ms_ev, up_ev, dn_ev, left_ev, right_ev;

  state_t           state;
  logic [CUR_W-1:0] cursor;
  logic [TICK_W-1:0] presc;
  logic             sec_pulse, set_active;
  logic             run_en, edit_en, sec_tick, inc_sel, dec_sel;

  logic [SEC_W-1:0] sec, min;
  logic [HR_W-1:0]  hr;
  logic             sec_carry_c, min_carry_c, hr_carry_unused;

  assign raw = {bus.i_right, bus.i_left, bus.i_down, bus.i_up, bus.i_ms_pulse};

  // One register stage per input, plus history for rising-edge detection.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      in_q  <= '0;
      in_d  <= '0;
      set_q <= 1'b0;
    end else begin
      in_q  <= raw;
      in_d  <= in_q;
      set_q <= bus.i_set;
    end
  end

  assign ev       = in_q & ~in_d;
  assign ms_ev    = ev[0];
  assign up_ev    = ev[1];
  assign dn_ev    = ev[2];
  assign left_ev  = ev[3];
  assign right_ev = ev[4];

  // Transition cycles (set_q disagreeing with state) neither count nor edit.
  assign run_en   = (state == ST_RUN) && !set_q;
  assign edit_en  = (state == ST_SET) && set_q;
  assign sec_tick = run_en && ms_ev && (presc == TICK_W'(TICKS_PER_SEC - 1));
  assign inc_sel  = edit_en && up_ev && !dn_ev;
  assign dec_sel  = edit_en && dn_ev && !up_ev;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state      <= ST_RUN;
      cursor     <= FLD_MIN;
      presc      <= '0;
      sec_pulse  <= 1'b0;
      set_active <= 1'b0;
    end else begin
      sec_pulse <= sec_tick;
      case (state)
        ST_RUN: begin
          if (set_q) begin
            state      <= ST_SET;
            set_active <= 1'b1;
            presc      <= '0;
            cursor     <= FLD_MIN;
          end else if (ms_ev) begin
            presc <= sec_tick ? '0 : presc + TICK_W'(1);
          end
        end
        ST_SET: begin
          if (!set_q) begin
            state      <= ST_RUN;
            set_active <= 1'b0;
            presc      <= '0;
          end else if (left_ev && !right_ev) begin
            cursor <= (cursor == FLD_LAST) ? FLD_SEC : cursor + CUR_W'(1);
          end else if (right_ev && !left_ev) begin
            cursor <= (cursor == FLD_SEC) ? FLD_LAST : cursor - CUR_W'(1);
          end
        end
        default: state <= ST_RUN;
      endcase
    end
  end

  clock_field_ctr #(.MAX(SEC_MAX), .W(SEC_W), .RST_VAL(0)) u_sec (
    .i_clk   (i_clk),
    .i_rstn  (i_rstn),
    .inc     (sec_tick || (inc_sel && cursor == FLD_SEC)),
    .dec     (dec_sel && cursor == FLD_SEC),
    .load    (1'b0),
    .load_val('0),
    .val     (sec),
    .carry_c (sec_carry_c)
  );

  clock_field_ctr #(.MAX(MIN_MAX), .W(SEC_W), .RST_VAL(0)) u_min (
    .i_clk   (i_clk),
    .i_rstn  (i_rstn),
    .inc     ((run_en && sec_carry_c) || (inc_sel && cursor == FLD_MIN)),
    .dec     (dec_sel && cursor == FLD_MIN),
    .load    (1'b0),
    .load_val('0),
    .val     (min),
    .carry_c (min_carry_c)
  );

  clock_field_ctr #(.MAX(HR_MAX), .W(HR_W), .RST_VAL(0)) u_hr (
    .i_clk   (i_clk),
    .i_rstn  (i_rstn),
    .inc     ((run_en && min_carry_c) || (inc_sel && cursor == FLD_HR)),
    .dec     (dec_sel && cursor == FLD_HR),
    .load    (1'b0),
    .load_val('0),
    .val     (hr),
    .carry_c (hr_carry_unused)
  );

  // Displayed hour applies the summertime offset, then optional 12 h folding.
  logic [HR_W-1:0] dh_sum, dh, hr12;
  assign dh_sum = hr + HR_W'(bus.i_summertime);
  assign dh     = (dh_sum > HR_W'(HR_MAX)) ? dh_sum - HR_W'(HR_MAX + 1) : dh_sum;
  assign hr12   = (dh == '0) ? HR_W'(12) : (dh > HR_W'(12)) ? dh - HR_W'(12) : dh;

  assign bus.o_sec        = sec;
  assign bus.o_min        = min;
  assign bus.o_hr         = bus.i_mode_12h ? hr12 : dh;
  assign bus.o_pm         = bus.i_mode_12h && (dh >= HR_W'(12));
  assign bus.o_set_active = set_active;
  assign bus.o_cursor     = cursor;
  assign bus.o_sec_pulse  = sec_pulse;

`ifdef CLOCK_ALARM_EN
  logic [SEC_W-1:0] alm_min, alarm_secs;
  logic [HR_W-1:0]  alm_hr;
  logic             alarm, alm_min_carry_unused, alm_hr_carry_unused;

  clock_field_ctr #(.MAX(MIN_MAX), .W(SEC_W), .RST_VAL(0)) u_alm_min (
    .i_clk   (i_clk),
    .i_rstn  (i_rstn),
    .inc     (inc_sel && cursor == FLD_ALM_MIN),
    .dec     (dec_sel && cursor == FLD_ALM_MIN),
    .load    (1'b0),
    .load_val('0),
    .val     (alm_min),
    .carry_c (alm_min_carry_unused)
  );

  clock_field_ctr #(.MAX(HR_MAX), .W(HR_W), .RST_VAL(7)) u_alm_hr (
    .i_clk   (i_clk),
    .i_rstn  (i_rstn),
    .inc     (inc_sel && cursor == FLD_ALM_HR),
    .dec     (dec_sel && cursor == FLD_ALM_HR),
    .load    (1'b0),
    .load_val('0),
    .val     (alm_hr),
    .carry_c (alm_hr_carry_unused)
  );

  // Match is checked the cycle after seconds advance, when the new time is visible.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      alarm      <= 1'b0;
      alarm_secs <= '0;
    end else if ((|ev[4:1]) || (state == ST_RUN && set_q)) begin
      alarm <= 1'b0;
    end else if (sec_pulse && run_en && sec == '0 && min == alm_min && dh == alm_hr) begin
      alarm      <= 1'b1;
      alarm_secs <= '0;
    end else if (alarm && sec_tick) begin
      if (alarm_secs == SEC_W'(SEC_MAX)) alarm <= 1'b0;
      else                               alarm_secs <= alarm_secs + SEC_W'(1);
    end
  end

  assign bus.o_alm_min = alm_min;
  assign bus.o_alm_hr  = alm_hr;
  assign bus.o_alarm   = alarm;
`endif

endmodule

// File: tb/tb_clock_core_gen2.sv
// Randomized scoreboard bench for clock_core_gen2 (TICKS_PER_SEC = 4, default build).
module tb_clock_core_gen2;

  localparam int TPS = 4;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  clock_core_gen2_if ifc();

  clock_core_gen2 #(.TICKS_PER_SEC(TPS)) dut (
    .i_clk (clk),
    .i_rstn(rstn),
    .bus   (ifc.slave)
  );

  typedef struct {
    int sec;
    int min;
    int hr;
  } tm_t;

  tm_t exp_q[$];
  int  vectors = 0;
  int  errs    = 0;

  // Reference model: field values [0]=sec [1]=min [2]=hr, cursor, tick count, mode.
  int m_f[3];
  int m_cur;
  int m_tick;
  bit m_run;

  task automatic chk(input string nm, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic int modv(input int c);
    return (c == 2) ? 24 : 60;
  endfunction

  function automatic int disp_hr(input int hr);
    int dh;
    dh = (hr + int'(ifc.i_summertime)) % 24;
    if (!ifc.i_mode_12h) return dh;
    return (dh % 12 == 0) ? 12 : dh % 12;
  endfunction

  function automatic int disp_pm(input int hr);
    int dh;
    dh = (hr + int'(ifc.i_summertime)) % 24;
    return (ifc.i_mode_12h && dh >= 12) ? 1 : 0;
  endfunction

  function automatic void advance_second();
    int t;
    t = ((m_f[2] * 3600 + m_f[1] * 60 + m_f[0]) + 1) % 86400;
    m_f[2] = t / 3600;
    m_f[1] = (t / 60) % 60;
    m_f[0] = t % 60;
  endfunction

  task automatic check_state(input string nm);
    #1;
    chk({nm, "_sec"},    int'(ifc.o_sec), m_f[0]);
    chk({nm, "_min"},    int'(ifc.o_min), m_f[1]);
    chk({nm, "_hr"},     int'(ifc.o_hr),  disp_hr(m_f[2]));
    chk({nm, "_pm"},     int'(ifc.o_pm),  disp_pm(m_f[2]));
    chk({nm, "_cursor"}, int'(ifc.o_cursor), m_cur);
    chk({nm, "_setact"}, int'(ifc.o_set_active), m_run ? 0 : 1);
  endtask

  task automatic chk_drained(input string nm);
    cyc(3);
    chk({nm, "_pending_pulses"}, exp_q.size(), 0);
  endtask

  task automatic ms_tick();
    int hi, lo;
    tm_t e;
    hi = $urandom_range(1, 3);
    lo = $urandom_range(1, 3);
    ifc.i_ms_pulse = 1'b1;
    if (m_run) begin
      m_tick++;
      if (m_tick == TPS) begin
        m_tick = 0;
        advance_second();
        e.sec = m_f[0]; e.min = m_f[1]; e.hr = m_f[2];
        exp_q.push_back(e);
      end
    end
    cyc(hi);
    ifc.i_ms_pulse = 1'b0;
    cyc(lo);
  endtask

  task automatic drive_btn(input int b, input logic v);
    case (b)
      0: ifc.i_up    = v;
      1: ifc.i_down  = v;
      2: ifc.i_left  = v;
      default: ifc.i_right = v;
    endcase
  endtask

  function automatic void edit(input int b);
    if (m_run) return;
    case (b)
      0: m_f[m_cur] = (m_f[m_cur] + 1) % modv(m_cur);
      1: m_f[m_cur] = (m_f[m_cur] + modv(m_cur) - 1) % modv(m_cur);
      2: m_cur = (m_cur + 1) % 3;
      default: m_cur = (m_cur + 2) % 3;
    endcase
  endfunction

  task automatic press(input int b, input int hold);
    drive_btn(b, 1'b1);
    edit(b);
    cyc(hold);
    drive_btn(b, 1'b0);
    cyc(2);
  endtask

  // Conflicting pair rising together: model expects no change.
  task automatic press2(input int a, input int b);
    drive_btn(a, 1'b1);
    drive_btn(b, 1'b1);
    cyc(1);
    drive_btn(a, 1'b0);
    drive_btn(b, 1'b0);
    cyc(2);
  endtask

  task automatic set_field(input int c, input int t);
    for (int k = 0; k < 3 && m_cur != c; k++) press(2, 1);
    for (int k = 0; k < 60 && m_f[c] != t; k++)
      press((((t - m_f[c] + modv(c)) % modv(c)) <= modv(c) / 2) ? 0 : 1, 1);
  endtask

  task automatic enter_set();
    ifc.i_set = 1'b1;
    m_run  = 1'b0;
    m_tick = 0;
    m_cur  = 1;
    cyc(3);
  endtask

  task automatic model_reset();
    m_f    = '{0, 0, 0};
    m_cur  = 1;
    m_tick = 0;
    m_run  = 1'b1;
  endtask

  // Monitor: every seconds strobe must match the oldest predicted second.
  initial begin : monitor
    tm_t e;
    forever begin
      @(negedge clk);
      if (rstn && ifc.o_sec_pulse) begin
        if (exp_q.size() == 0) begin
          vectors++;
          errs++;
          $display("FAIL spurious_sec_pulse: got pulse at %0d:%0d:%0d, expected none (t=%0t)",
                   ifc.o_hr, ifc.o_min, ifc.o_sec, $time);
        end else begin
          e = exp_q.pop_front();
          chk("pulse_sec", int'(ifc.o_sec), e.sec);
          chk("pulse_min", int'(ifc.o_min), e.min);
          chk("pulse_hr",  int'(ifc.o_hr),  disp_hr(e.hr));
          chk("pulse_pm",  int'(ifc.o_pm),  disp_pm(e.hr));
        end
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    ifc.i_ms_pulse = 1'b0; ifc.i_set = 1'b0;
    ifc.i_up = 1'b0; ifc.i_down = 1'b0; ifc.i_left = 1'b0; ifc.i_right = 1'b0;
    ifc.i_summertime = 1'b0; ifc.i_mode_12h = 1'b0;
    model_reset();
    rstn = 1'b0;
    cyc(3);
    rstn = 1'b1;
    cyc(2);
    check_state("reset24");
    ifc.i_mode_12h = 1'b1;
    check_state("reset12");
    ifc.i_mode_12h = 1'b0;

    // First second, then a random run with live display-mode changes.
    repeat (TPS) ms_tick();
    chk_drained("first_sec");
    check_state("first_sec");
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 7) == 0) ifc.i_summertime = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) ifc.i_mode_12h   = 1'($urandom_range(0, 1));
      ms_tick();
    end
    chk_drained("run1");
    check_state("run1");

    // SET entry freezes time.
    enter_set();
    check_state("set_entry");
    repeat (6) ms_tick();
    check_state("set_frozen");
    set_field(1, 0);
    repeat (3) press(0, 1);
    check_state("min_up3");
    press(2, 1);
    check_state("cursor_left");
    set_field(2, 0);
    press(1, 1);
    check_state("hr_down_wrap");
    set_field(0, 59);
    press(0, 1);
    check_state("sec_wrap_nocarry");
    press(3, 1);
    check_state("cursor_right_wrap");

    for (int i = 0; i < 30; i++) begin
      press($urandom_range(0, 3), $urandom_range(1, 20));
      check_state("rand_edit");
    end
    press2(0, 1);
    check_state("up_down_conflict");
    press2(2, 3);
    check_state("left_right_conflict");
    press(0, 20);
    check_state("held_up");

    // Display folding and summertime on edited hours.
    ifc.i_summertime = 1'b0;
    ifc.i_mode_12h   = 1'b1;
    set_field(2, 13);
    check_state("disp_13_12h");
    set_field(2, 0);
    check_state("disp_0_12h");
    set_field(2, 23);
    ifc.i_summertime = 1'b1;
    check_state("disp_23st_12h");
    ifc.i_mode_12h = 1'b0;
    check_state("disp_23st_24h");
    ifc.i_summertime = 1'b0;

    // Preload 23:59:59 and leave SET with a button edge in the same cycle.
    set_field(2, 23);
    set_field(1, 59);
    set_field(0, 59);
    ifc.i_set = 1'b0;
    ifc.i_up  = 1'b1;
    m_run  = 1'b1;
    m_tick = 0;
    cyc(2);
    ifc.i_up = 1'b0;
    cyc(2);
    check_state("set_exit");
    repeat (TPS - 1) ms_tick();
    check_state("exit_partial_sec");
    ms_tick();
    chk_drained("day_wrap");
    check_state("day_wrap");

    // Buttons in RUN are ignored.
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 3))
        0: press($urandom_range(0, 3), $urandom_range(1, 4));
        1: ifc.i_summertime = 1'($urandom_range(0, 1));
        default: ms_tick();
      endcase
    end
    chk_drained("run2");
    check_state("run2");

    // Asynchronous reset in the middle of SET.
    enter_set();
    set_field(1, 17);
    press(2, 1);
    @(posedge clk);
    #3;
    rstn = 1'b0;
    ifc.i_set = 1'b0;
    model_reset();
    check_state("async_rst");
    cyc(2);
    rstn = 1'b1;
    cyc(2);
    check_state("post_rst");
    repeat (3 * TPS) ms_tick();
    chk_drained("post_rst_run");
    check_state("post_rst_run");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule

// File: doc/clock_core_gen2.md
Name: clock_core_gen2

Overview:
Second-generation timekeeping core for the board clock. It counts seconds, minutes and hours from a millisecond tick and supports interactive time setting with a field cursor driven by up/down/left/right buttons. It adds three things to the previous clock: a parametrised tick prescaler, a 12/24-hour display mode, and a seconds strobe for downstream display and alarm logic. It sits between the ms-tick generator and button conditioner on one side and the 7-segment/display driver on the other.

Parameters:
TICKS_PER_SEC, 1000, number of i_ms_pulse rising edges per second (legal range 2..65535)
TICK_W, $clog2(TICKS_PER_SEC), prescaler width (derived; do not override)

Ports:
i_clk  in  1  system clock
i_rstn  in  1  reset, asynchronous, active-low
i_ms_pulse  in  1  ms tick, level; only the rising edge counts
i_set  in  1  level; high = SET mode, low = RUN
i_up  in  1  increment selected field; rising edge counts
i_down  in  1  decrement selected field; rising edge counts
i_left  in  1  move cursor to a higher field; rising edge counts
i_right  in  1  move cursor to a lower field; rising edge counts
i_summertime  in  1  adds +1 h to the displayed hour
i_mode_12h  in  1  1 = 12 h display, 0 = 24 h display
o_sec  out  6  displayed seconds 0..59
o_min  out  6  displayed minutes 0..59
o_hr  out  5  displayed hour: 0..23 in 24 h mode, 1..12 in 12 h mode
o_pm  out  1  PM flag in 12 h mode; 0 in 24 h mode
o_set_active  out  1  registered copy of the SET state
o_cursor  out  3  selected field: 0 = SEC, 1 = MIN, 2 = HR (3, 4 only with the alarm macro)
o_sec_pulse  out  1  one-cycle strobe when seconds advance in RUN

Behaviour:
- Reset (asynchronous): base time 00:00:00, prescaler 0, state RUN, cursor MIN (1), all edge-detect history 0, o_sec_pulse 0, o_set_active 0. After release, display shows 00 h in 24 h mode, or 12 h with o_pm = 0 in 12 h mode.
- Edge detection: every pulse and button input is registered once; an event is in_q & ~in_q_d. Each event is exactly one cycle long.
- Holding a button produces one action only.
- Latency: a state or count update occurs 2 clk cycles after the input is first sampled high.
- FSM RUN:
  - Each ms event increments the prescaler.
  - When the prescaler reaches TICKS_PER_SEC-1 and another ms event arrives, the prescaler goes to 0, sec increments and o_sec_pulse asserts for 1 cycle.
  - Carry chain: 59→0 on sec carries to min; 59→0 on min carries to hr; 23→0 on hr wraps, with no further carry.
  - Buttons are ignored in RUN.
- RUN→SET on i_set = 1:
  - Prescaler clears and is held at 0.
  - Time is frozen; o_sec_pulse stays 0.
  - Cursor is forced to MIN on entry.
- FSM SET:
  - up/down modify only the selected field, wrapping modulo its range (sec/min 0..59, hr 0..23). There is no carry into neighbouring fields.
  - left moves the cursor up: SEC→MIN→HR→SEC. right moves it down: SEC→HR→MIN→SEC.
  - Simultaneous up & down events in the same cycle: no change. Simultaneous left & right: no change.
  - A button event in the same cycle as the i_set fall is ignored.
- SET→RUN on i_set = 0: the prescaler restarts from 0, so the first second after exit is a full TICKS_PER_SEC ticks.
- Display hour: dh = (base_hr + i_summertime) mod 24.
  - 24 h mode: o_hr = dh.
  - 12 h mode: o_hr = 12 when dh is 0 or 12, dh-12 when dh > 12, otherwise dh. o_pm = (dh >= 12).
  - Display outputs are combinational from the base registers plus i_summertime/i_mode_12h.
- Mode and summertime changes take effect immediately and never alter base time.
- HR edits in SET act on base_hr, so the displayed hour tracks the edit plus the summertime offset.

Optional Feature:
CLOCK_ALARM_EN
- Defined:
  - Adds alarm registers alm_min (reset 0) and alm_hr (reset 7).
  - Cursor range is 0..4: 3 = ALM_MIN, 4 = ALM_HR. left wraps 4→0; right wraps 0→4.
  - Adds ports o_alm_min[5:0], o_alm_hr[4:0] and o_alarm.
  - o_alarm sets in RUN when dh == alm_hr, min == alm_min and sec steps to 0.
  - o_alarm clears after 60 s, on any button event, or on entry to SET.
- Undefined: the alarm ports and logic are absent, and the cursor cycles 0..2 only.

Decomposition:
- Package clock_pkg: cursor field encodings (FLD_SEC, FLD_MIN, FLD_HR, FLD_ALM_MIN, FLD_ALM_HR), limits SEC_MAX = 59, MIN_MAX = 59, HR_MAX = 23, FSM state encodings ST_RUN, ST_SET.
- Sub-module clock_field_ctr: modulo-N up/down counter with parameter MAX, inc/dec/load inputs and a carry-out on MAX→0. Instantiated for sec, min and hr (and both alarm fields when CLOCK_ALARM_EN is defined).

Test Plan:
- Tick count and carry (TICKS_PER_SEC = 4): reset, then 4 ms pulses → o_sec = 1 and exactly one o_sec_pulse. Preload 23:59:59 and apply 4 pulses → 00:00:00 with no spurious carry.
- SET editing: i_set = 1 → o_cursor = 1, time frozen under continuing ms pulses. up ×3 → min = 3. left → cursor 2. down on hr = 0 → hr = 23. i_set = 0 → seconds resume after a full 4 ticks.
- Wrap without carry: in SET, sec = 59 and up → sec = 0, min unchanged. right from cursor 0 → cursor 2.
- Display modes: base hr 0 with 12 h mode → o_hr = 12, o_pm = 0. Base 13 → o_hr = 1, o_pm = 1. Base 23 with summertime → 24 h o_hr = 0, 12 h o_hr = 12, o_pm = 0.
- Edge and conflict rules: up held for 20 cycles → single increment. up & down rising in the same cycle → no change. i_rstn pulsed low mid-SET → immediate 00:00:00, RUN, cursor 1.
- With CLOCK_ALARM_EN: set alarm 00:01 and run from 00:00:59 → o_alarm rises at 00:01:00. Any button event → o_alarm = 0.
